// File: rtl/binary_to_gray_behavioural_if.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_gray_behavioural_if
// Brief    : Bus bundle for the registered binary/Gray code converter.
//            The master drives the code word, qualifier and direction.
//            The slave returns the converted word, valid strobe and
//            single-step flag.
// Revision : 1.0  initial release
// ============================================================================
interface binary_to_gray_behavioural_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             dir;
  logic [WIDTH-1:0] g;
  logic             g_valid;
  logic             step_ok;

  modport master (
    output b, in_valid, dir,
    input  g, g_valid, step_ok
  );

  modport slave (
    input  b, in_valid, dir,
    output g, g_valid, step_ok
  );
endinterface
`default_nettype wire

// File: rtl/binary_to_gray_behavioural.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_gray_behavioural
// Brief    : Registered binary <-> reflected-Gray converter with a valid
//            strobe and a Gray adjacency flag. Latency is one clock and
//            throughput is one word per clock.
// Revision : 1.0  initial release
// ============================================================================
module binary_to_gray_behavioural #(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  binary_to_gray_behavioural_if.slave   bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Gray to binary: prefix XOR running from the MSB down to the LSB.
  function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ v[i];
    end
    return r;
  endfunction

  // True when exactly one bit is set (non-zero power of two).
  function automatic logic one_hot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  logic [WIDTH-1:0] g_q,       g_d;
  logic             g_valid_q, g_valid_d;
  logic             step_ok_q, step_ok_d;
  logic [WIDTH-1:0] hist_q,    hist_d;
  logic             have_prev_q, have_prev_d;
  logic [WIDTH-1:0] conv;

  // Next-state: convert the accepted word and, for binary-to-Gray accepts,
  // compare it against the previous Gray word to flag a single-bit step.
  always_comb begin
    conv        = bus.dir ? to_bin(bus.b) : to_gray(bus.b);
    g_d         = g_q;
    g_valid_d   = 1'b0;
    step_ok_d   = 1'b0;
    hist_d      = hist_q;
    have_prev_d = have_prev_q;
    if (bus.in_valid) begin
      g_d       = conv;
      g_valid_d = 1'b1;
      if (!bus.dir) begin
        // Identical words give a zero XOR, so one_hot rejects them.
        step_ok_d   = have_prev_q && one_hot(conv ^ hist_q);
        hist_d      = conv;
        have_prev_d = 1'b1;
      end
    end
  end

  // State and output registers; reset clears everything including history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q         <= '0;
      g_valid_q   <= 1'b0;
      step_ok_q   <= 1'b0;
      hist_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      g_q         <= g_d;
      g_valid_q   <= g_valid_d;
      step_ok_q   <= step_ok_d;
      hist_q      <= hist_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign bus.g       = g_q;
  assign bus.g_valid = g_valid_q;
  assign bus.step_ok = step_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_gray_behavioural.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_to_gray_behavioural
// Brief    : Self-checking bench for binary_to_gray_behavioural. A 4-bit
//            instance covers the directed plan and random traffic; an 8-bit
//            instance covers the full round trip.
// Revision : 1.0  initial release
// ============================================================================
module tb_binary_to_gray_behavioural;

  logic clk;
  logic rst_n;

  binary_to_gray_behavioural_if #(.WIDTH(4)) bus4 ();
  binary_to_gray_behavioural_if #(.WIDTH(8)) bus8 ();

  binary_to_gray_behavioural #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  binary_to_gray_behavioural #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: Gray code from its arithmetic definition, inverse by
  // exhaustive search over the code space.
  function automatic int ref_gray(input int x);
    return x ^ (x >> 1);
  endfunction

  function automatic int ref_bin(input int gv, input int w);
    for (int x = 0; x < (1 << w); x++) begin
      if (ref_gray(x) == gv) return x;
    end
    return -1;
  endfunction

  int m_g, m_hist;
  bit m_gv, m_sok, m_hp;

  task automatic model_reset();
    m_g = 0; m_gv = 0; m_sok = 0; m_hist = 0; m_hp = 0;
  endtask

  task automatic model_edge(input bit v, input bit d, input int bv);
    if (v) begin
      m_g  = d ? ref_bin(bv, 4) : ref_gray(bv);
      m_gv = 1;
      if (!d) begin
        m_sok  = m_hp && ($countones(m_g ^ m_hist) == 1);
        m_hist = m_g;
        m_hp   = 1;
      end else begin
        m_sok = 0;
      end
    end else begin
      m_gv  = 0;
      m_sok = 0;
    end
  endtask

  // One clock on the 4-bit instance, checked against the model.
  task automatic cyc4(input bit v, input bit d, input int bv, input string tag);
    @(negedge clk);
    bus4.in_valid = v;
    bus4.dir      = d;
    bus4.b        = bv[3:0];
    @(posedge clk);
    model_edge(v, d, bv);
    #1;
    check({tag, "_g"},    32'(bus4.g),       32'(m_g));
    check({tag, "_gv"},   32'(bus4.g_valid), 32'(m_gv));
    check({tag, "_step"}, 32'(bus4.step_ok), 32'(m_sok));
  endtask

  // One clock on the 8-bit instance.
  task automatic cyc8(input bit v, input bit d, input logic [7:0] bv);
    @(negedge clk);
    bus8.in_valid = v;
    bus8.dir      = d;
    bus8.b        = bv;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  int g2b_in  [4] = '{8, 7, 12, 0};
  int g2b_exp [4] = '{15, 5, 8, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] gtmp;
    rst_n = 1'b0;
    bus4.in_valid = 0; bus4.dir = 0; bus4.b = '0;
    bus8.in_valid = 0; bus8.dir = 0; bus8.b = '0;
    model_reset();
    #12;
    check("rst_g",     32'(bus4.g),       0);
    check("rst_gv",    32'(bus4.g_valid), 0);
    check("rst_step",  32'(bus4.step_ok), 0);
    check("rst_g8",    32'(bus8.g),       0);
    @(negedge clk);
    rst_n = 1'b1;

    // Incrementing sweep in binary-to-Gray mode.
    for (int i = 0; i < 16; i++) begin
      cyc4(1, 0, i, "sweep");
      check("sweep_tbl",  32'(bus4.g),       32'(sweep_tbl[i]));
      check("sweep_stp",  32'(bus4.step_ok), (i == 0) ? 0 : 1);
    end

    // Gray-to-binary directed points.
    for (int i = 0; i < 4; i++) begin
      cyc4(1, 1, g2b_in[i], "g2b");
      check("g2b_tbl", 32'(bus4.g),       32'(g2b_exp[i]));
      check("g2b_stp", 32'(bus4.step_ok), 0);
    end

    // Wrap-around and adjacency corner cases.
    cyc4(1, 0, 15, "wrap_a");
    check("wrap_a_tbl", 32'(bus4.g), 8);
    cyc4(1, 0, 0,  "wrap_b");
    check("wrap_b_tbl", 32'(bus4.g), 0);
    check("wrap_b_stp", 32'(bus4.step_ok), 1);
    cyc4(1, 0, 3, "adj_a");
    check("adj_a_tbl", 32'(bus4.g), 2);
    cyc4(1, 0, 5, "adj_b");
    check("adj_b_tbl", 32'(bus4.g), 7);
    check("adj_b_stp", 32'(bus4.step_ok), 0);
    cyc4(1, 0, 5, "repeat");
    check("repeat_stp", 32'(bus4.step_ok), 0);

    // Hold with in_valid low while b changes.
    cyc4(1, 0, 9, "hold_acc");
    check("hold_acc_tbl", 32'(bus4.g), 13);
    for (int i = 0; i < 3; i++) begin
      cyc4(0, 0, 2, "hold");
      check("hold_tbl", 32'(bus4.g), 13);
    end

    // Asynchronous reset between clock edges while streaming.
    cyc4(1, 0, 5, "pre_rst");
    cyc4(1, 0, 6, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_g",    32'(bus4.g),       0);
    check("arst_gv",   32'(bus4.g_valid), 0);
    check("arst_step", 32'(bus4.step_ok), 0);
    @(negedge clk);
    bus4.in_valid = 0;
    rst_n = 1'b1;
    cyc4(1, 0, 1, "post_rst_a");
    check("post_rst_a_tbl", 32'(bus4.g), 1);
    check("post_rst_a_stp", 32'(bus4.step_ok), 0);
    cyc4(1, 0, 2, "post_rst_b");
    check("post_rst_b_tbl", 32'(bus4.g), 3);
    check("post_rst_b_stp", 32'(bus4.step_ok), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cyc4(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), "rand");
    end
    cyc4(0, 0, 0, "idle");

    // Full round trip on the 8-bit instance.
    for (int x = 0; x < 256; x++) begin
      cyc8(1, 0, 8'(x));
      check("rt_fwd", 32'(bus8.g), 32'(ref_gray(x)));
      gtmp = bus8.g;
      cyc8(1, 1, gtmp);
      check("rt_back", 32'(bus8.g), 32'(x));
      check("rt_gv",   32'(bus8.g_valid), 1);
    end
    cyc8(0, 0, 8'd0);
    check("rt_idle_gv", 32'(bus8.g_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/binary_to_gray_behavioural.md
Name: binary_to_gray_behavioural

Overview:
- Registered, parameterised code converter between plain binary and reflected Gray code; default direction is binary to Gray.
- Sits on counter/pointer paths, e.g. FIFO pointers crossing clock domains or position encoders.
- Produces a one-cycle-latency registered result with a valid strobe.
- Produces a single-step flag confirming that consecutive Gray outputs differ in exactly one bit.

Parameters:
- WIDTH, 4, bit width of input code and output code (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- b  input  WIDTH  input code word (binary when dir=0, Gray when dir=1)
- in_valid  input  1  qualifies b/dir on the current rising edge
- dir  input  1  0 = binary-to-Gray, 1 = Gray-to-binary
- g  output  WIDTH  registered converted code word
- g_valid  output  1  high for one cycle per accepted input
- step_ok  output  1  Gray adjacency flag, valid only with g_valid

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. rst_n=0 immediately forces:
  - g=0, g_valid=0, step_ok=0
  - history register cleared
  - "have_prev" flag cleared
- Reset dominates all other inputs. Deassertion takes effect on the first rising edge with rst_n=1.
- Binary-to-Gray (dir=0): result = b XOR (b >> 1), i.e. result[WIDTH-1]=b[WIDTH-1] and result[i]=b[i+1]^b[i].
- Gray-to-binary (dir=1): result[WIDTH-1]=b[WIDTH-1], then result[i]=result[i+1]^b[i], computed MSB to LSB as a prefix XOR.
- Latency: exactly 1 clock. At the rising edge where in_valid=1:
  - g <= result
  - g_valid <= 1
- Edge with in_valid=0:
  - g holds its previous value
  - g_valid <= 0
  - step_ok <= 0
- Back-to-back: in_valid may be high every cycle; throughput is one word per clock with no stall and no backpressure.
- Adjacency check applies to dir=0 accepts only:
  - Compare the new Gray result against the last Gray result accepted with dir=0 (the history register).
  - step_ok <= 1 if have_prev=1 and the XOR of the two has exactly one bit set; otherwise 0.
  - Identical consecutive values give 0.
  - On the same edge, history <= new result and have_prev <= 1.
- dir=1 accepts:
  - step_ok <= 0.
  - History and have_prev unchanged.
- Wrap-around: binary (2^WIDTH − 1) to 0 maps Gray 100..0 to 000..0, a single-bit change, so step_ok=1.
- dir may change on any edge. Each accepted word uses the dir sampled on that edge; there is no state carried in the datapath.
- Reset mid-stream:
  - Outputs clear asynchronously.
  - The first dir=0 accept after reset always gives step_ok=0 because have_prev=0.
- No X propagation: the design assumes b and dir are known whenever in_valid=1. When in_valid=0, the values on b and dir are ignored.
- Round trip: for any binary x, converting with dir=0 and feeding the result back with dir=1 returns x.

Test Plan:
- Sweep with dir=0 and in_valid=1, b=0..15 on consecutive clocks → g one clock later = 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. step_ok=0 for the first word and 1 for all later words.
- Gray-to-binary with dir=1: b=8 → g=15; b=7 → g=5; b=12 → g=8; b=0 → g=0. step_ok=0 throughout.
- Wrap and adjacency:
  - dir=0, b=15 then b=0 → g=8 then g=0 with step_ok=1.
  - dir=0, b=3 then b=5 → g=2 then g=7 with step_ok=0 (two bits differ).
  - Repeating b=5 → step_ok=0.
- Hold and valid: accept b=9 (g=13), then drive in_valid=0 with b=2 for 3 cycles → g stays 13, g_valid=0, step_ok=0.
- Asynchronous reset mid-stream: while streaming dir=0, assert rst_n=0 between edges → g=0, g_valid=0, step_ok=0 immediately. After release, b=1 then b=2 → g=1 (step_ok=0), then g=3 (step_ok=1).
- Round trip with WIDTH=8: for all x in 0..255, convert with dir=0, then feed g back with dir=1 → output equals x.
